// File: rtl/present_pkg.sv
// present_pkg: shared constants, types and helpers for the PRESENT-80 peripheral.
//   - SBOX / SBOX_INV : 4-bit S-box tables; entry n lives in bits [4n+3:4n]
//   - sbox / sbox_inv : nibble lookups
//   - p_layer / p_layer_inv : bit permutation (bit j -> 16*j mod 63, bit 63 fixed)
//   - ADDR_* : register map of the bus interface
//   - fsm_t  : wrapper FSM states
package present_pkg;

  localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;

  localparam logic [3:0] ADDR_CTRL  = 4'd0;
  localparam logic [3:0] ADDR_KEY0  = 4'd1;
  localparam logic [3:0] ADDR_KEY1  = 4'd2;
  localparam logic [3:0] ADDR_KEY2  = 4'd3;
  localparam logic [3:0] ADDR_DIN0  = 4'd4;
  localparam logic [3:0] ADDR_DIN1  = 4'd5;
  localparam logic [3:0] ADDR_DOUT0 = 4'd6;
  localparam logic [3:0] ADDR_DOUT1 = 4'd7;
  localparam logic [3:0] ADDR_MODE  = 4'd8;

  // Step counter terminal values: 31 key-schedule steps, 32 round steps.
  localparam logic [4:0] KEYEXP_LAST = 5'd30;
  localparam logic [4:0] ROUND_LAST  = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } fsm_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    return SBOX_INV[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 63; j++) y[6'((16 * j) % 63)] = x[6'(j)];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [63:0] p_layer_inv(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 63; j++) y[6'(j)] = x[6'((16 * j) % 63)];
    y[63] = x[63];
    return y;
  endfunction

endpackage

// File: rtl/present_round.sv
// present_round: purely combinational PRESENT-80 round and key-schedule step.
//   i_state     : 64-bit cipher state entering the step
//   i_key       : 80-bit current round-key register
//   i_rc        : 5-bit round counter mixed into key bits [19:15]
//   o_enc_state : sLayer/pLayer applied to (state ^ key[79:16])
//   o_enc_key   : forward key update (rotl 61, S-box on top nibble, counter xor)
//   o_dec_state : inverse pLayer/inverse sLayer of (state ^ key[79:16])
//   o_dec_key   : exact inverse of the forward key update
// Build option: PRESENT_DECRYPT_EN adds the o_dec_* ports and inverse logic.
module present_round
  import present_pkg::*;
(
  input  logic [63:0] i_state,
  input  logic [79:0] i_key,
  input  logic [4:0]  i_rc,
  output logic [63:0] o_enc_state,
  output logic [79:0] o_enc_key
`ifdef PRESENT_DECRYPT_EN
  ,
  output logic [63:0] o_dec_state,
  output logic [79:0] o_dec_key
`endif
);

  logic [63:0] w_ark;
  logic [63:0] w_sub;
  logic [79:0] w_rot;

  // Both directions start by adding the current round key.
  assign w_ark = i_state ^ i_key[79:16];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      assign w_sub[gi*4 +: 4] = sbox(w_ark[gi*4 +: 4]);
    end
  endgenerate

  assign o_enc_state = p_layer(w_sub);

  assign w_rot     = {i_key[18:0], i_key[79:19]};
  assign o_enc_key = {sbox(w_rot[79:76]), w_rot[75:20], w_rot[19:15] ^ i_rc, w_rot[14:0]};

`ifdef PRESENT_DECRYPT_EN
  logic [63:0] w_inv_p;
  logic [79:0] w_unmix;

  assign w_inv_p = p_layer_inv(w_ark);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox_inv
      assign o_dec_state[gi*4 +: 4] = sbox_inv(w_inv_p[gi*4 +: 4]);
    end
  endgenerate

  // Undo counter xor and S-box, then rotate right by 61 (= left by 19).
  assign w_unmix   = {sbox_inv(i_key[79:76]), i_key[75:20], i_key[19:15] ^ i_rc, i_key[14:0]};
  assign o_dec_key = {w_unmix[60:0], w_unmix[79:61]};
`endif

endmodule

// File: rtl/present_wrapper.sv
// present_wrapper: memory-mapped PRESENT-80 cipher, one round per clock.
//   clk      : system clock (rising edge)
//   reset_n  : synchronous active-low reset
//   idat     : 32-bit write data
//   enable_n : chip select (active-low)
//   write_n  : write strobe (active-low)
//   read_n   : read strobe (active-low)
//   address  : 4-bit register select (CTRL, KEY0..2, DIN0..1, DOUT0..1, MODE)
//   odat     : combinational read data, 0 unless a read is strobed
// Build option: PRESENT_DECRYPT_EN enables MODE, the KEYEXP state and decrypt.
module present_wrapper
  import present_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] idat,
  input  logic        enable_n,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [3:0]  address,
  output logic [31:0] odat
);

  fsm_t        r_fsm;
  fsm_t        w_fsm_next;
  logic [79:0] r_key;
  logic [79:0] r_rkey;
  logic [63:0] r_din;
  logic [63:0] r_state;
  logic [63:0] r_dout;
  logic        r_done;
  logic [4:0]  r_step;

  logic        w_wr;
  logic        w_start;
  logic        w_mode;
  logic        w_in_keyexp;
  logic        w_in_round;
  logic        w_in_done;
  logic        w_last_round;
  logic [4:0]  w_rc;
  logic [63:0] w_enc_state;
  logic [79:0] w_enc_key;
  logic [31:0] w_rdata;

`ifdef PRESENT_DECRYPT_EN
  logic        r_mode;
  logic        r_dec;      // direction of the operation in flight
  logic [63:0] w_dec_state;
  logic [79:0] w_dec_key;
  assign w_mode = r_mode;
`else
  assign w_mode = 1'b0;
`endif

  assign w_wr    = !enable_n && !write_n;
  assign w_start = w_wr && (address == ADDR_CTRL) && idat[0] && (r_fsm == ST_IDLE);

  present_round u_round (
    .i_state     (r_state),
    .i_key       (r_rkey),
    .i_rc        (w_rc),
    .o_enc_state (w_enc_state),
    .o_enc_key   (w_enc_key)
`ifdef PRESENT_DECRYPT_EN
    ,
    .o_dec_state (w_dec_state),
    .o_dec_key   (w_dec_key)
`endif
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_fsm <= ST_IDLE;
    else          r_fsm <= w_fsm_next;
  end

  // FSM next-state logic
  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      ST_IDLE:   if (w_start) w_fsm_next = w_mode ? ST_KEYEXP : ST_ROUND;
`ifdef PRESENT_DECRYPT_EN
      ST_KEYEXP: if (r_step == KEYEXP_LAST) w_fsm_next = ST_ROUND;
`endif
      ST_ROUND:  if (r_step == ROUND_LAST) w_fsm_next = ST_DONE;
      ST_DONE:   w_fsm_next = ST_IDLE;
      default:   w_fsm_next = ST_IDLE;
    endcase
  end

  // FSM outputs: datapath controls
  always_comb begin
`ifdef PRESENT_DECRYPT_EN
    w_in_keyexp = (r_fsm == ST_KEYEXP);
`else
    w_in_keyexp = 1'b0;
`endif
    w_in_round   = (r_fsm == ST_ROUND);
    w_in_done    = (r_fsm == ST_DONE);
    w_last_round = w_in_round && (r_step == ROUND_LAST);
  end

  // Forward steps count the round number up from 1; decrypt rounds walk
  // the schedule back down from 31 so the inverse key update sees the
  // same counter that produced the key it is undoing.
`ifdef PRESENT_DECRYPT_EN
  assign w_rc = (w_in_round && r_dec) ? (ROUND_LAST - r_step) : (r_step + 5'd1);
`else
  assign w_rc = r_step + 5'd1;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_key   <= '0;
      r_rkey  <= '0;
      r_din   <= '0;
      r_state <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_step  <= '0;
`ifdef PRESENT_DECRYPT_EN
      r_mode  <= 1'b0;
      r_dec   <= 1'b0;
`endif
    end else begin
      if (w_wr) begin
        case (address)
          ADDR_KEY0: r_key[79:48] <= idat;
          ADDR_KEY1: r_key[47:16] <= idat;
          ADDR_KEY2: r_key[15:0]  <= idat[15:0];
          ADDR_DIN0: r_din[63:32] <= idat;
          ADDR_DIN1: r_din[31:0]  <= idat;
`ifdef PRESENT_DECRYPT_EN
          ADDR_MODE: r_mode       <= idat[0];
`endif
          default: ;
        endcase
      end

      // Operands are copied at start so later bus writes cannot disturb
      // the operation in flight.
      if (w_start) begin
        r_state <= r_din;
        r_rkey  <= r_key;
        r_step  <= '0;
        r_done  <= 1'b0;
`ifdef PRESENT_DECRYPT_EN
        r_dec   <= r_mode;
`endif
      end else if (w_in_keyexp) begin
        r_rkey <= w_enc_key;
        r_step <= (r_step == KEYEXP_LAST) ? 5'd0 : r_step + 5'd1;
      end else if (w_in_round) begin
        r_step <= r_step + 5'd1;
        if (w_last_round) begin
          // Final whitening: K_32 for encrypt, K_1 for decrypt.
          r_state <= r_state ^ r_rkey[79:16];
        end else begin
`ifdef PRESENT_DECRYPT_EN
          if (r_dec) begin
            r_state <= w_dec_state;
            r_rkey  <= w_dec_key;
          end else begin
            r_state <= w_enc_state;
            r_rkey  <= w_enc_key;
          end
`else
          r_state <= w_enc_state;
          r_rkey  <= w_enc_key;
`endif
        end
      end else if (w_in_done) begin
        r_dout <= r_state;
        r_done <= 1'b1;
      end
    end
  end

  // Read path: combinational, no side effects
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_CTRL:  w_rdata = {31'b0, r_done};
      ADDR_KEY0:  w_rdata = r_key[79:48];
      ADDR_KEY1:  w_rdata = r_key[47:16];
      ADDR_KEY2:  w_rdata = {16'b0, r_key[15:0]};
      ADDR_DIN0:  w_rdata = r_din[63:32];
      ADDR_DIN1:  w_rdata = r_din[31:0];
      ADDR_DOUT0: w_rdata = r_dout[63:32];
      ADDR_DOUT1: w_rdata = r_dout[31:0];
`ifdef PRESENT_DECRYPT_EN
      ADDR_MODE:  w_rdata = {31'b0, r_mode};
`endif
      default:    w_rdata = '0;
    endcase
    odat = (!enable_n && !read_n) ? w_rdata : 32'd0;
  end

endmodule

// File: tb/tb_present_wrapper.sv
module tb_present_wrapper;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] idat = '0;
  logic        enable_n = 1'b1;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [3:0]  address = '0;
  logic [31:0] odat;

  present_wrapper dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .idat     (idat),
    .enable_n (enable_n),
    .write_n  (write_n),
    .read_n   (read_n),
    .address  (address),
    .odat     (odat)
  );

  always #5 clk = ~clk;

`ifdef PRESENT_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected read data and a label per checked bus cycle.
  logic [31:0] exp_q[$];
  string       name_q[$];
  bit          chk_valid = 1'b0;

  // Shadow of the programmer-visible registers.
  logic [79:0] sh_key  = '0;
  logic [63:0] sh_din  = '0;
  logic [63:0] sh_dout = '0;
  bit          sh_mode = 1'b0;
  bit          sh_done = 1'b0;

  int sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  // Reference cipher: round keys are precomputed by the forward schedule
  // and applied in reverse for decryption.
  function automatic logic [63:0] model(input logic [79:0] key, input logic [63:0] blk, input bit dec);
    logic [63:0] rk [1:32];
    logic [79:0] k;
    logic [63:0] s;
    logic [63:0] t;
    int          sbi [16];
    for (int v = 0; v < 16; v++) sbi[4'(sb[v])] = v;
    k = key;
    for (int i = 1; i <= 32; i++) begin
      rk[i] = k[79:16];
      k = {k[18:0], k[79:19]};
      k[79:76] = 4'(sb[k[79:76]]);
      k[19:15] = k[19:15] ^ 5'(i);
    end
    if (!dec) begin
      s = blk;
      for (int i = 1; i <= 31; i++) begin
        s = s ^ rk[i];
        for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
        t = '0;
        for (int j = 0; j < 63; j++) t[6'((16 * j) % 63)] = s[6'(j)];
        t[63] = s[63];
        s = t;
      end
      s = s ^ rk[32];
    end else begin
      s = blk ^ rk[32];
      for (int i = 31; i >= 1; i--) begin
        t = '0;
        for (int j = 0; j < 63; j++) t[6'(j)] = s[6'((16 * j) % 63)];
        t[63] = s[63];
        for (int n = 0; n < 16; n++) t[4*n +: 4] = 4'(sbi[t[4*n +: 4]]);
        s = t ^ rk[i];
      end
    end
    return s;
  endfunction

  // Monitor: compares odat on the falling edge of every checked cycle.
  always @(negedge clk) begin
    if (chk_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: odat=%08h with no expected value", odat);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (odat !== e) begin
          errors++;
          $display("FAIL %s: odat=%08h required %08h", n, odat, e);
        end else begin
          $display("ok   %s: odat=%08h", n, odat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable_n  = 1'b1;
    write_n   = 1'b1;
    read_n    = 1'b1;
    chk_valid = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    enable_n = 1'b0; write_n = 1'b0; read_n = 1'b1; address = a; idat = d; chk_valid = 1'b0;
    tick();
    idle();
    case (a)
      4'd1: sh_key[79:48] = d;
      4'd2: sh_key[47:16] = d;
      4'd3: sh_key[15:0]  = d[15:0];
      4'd4: sh_din[63:32] = d;
      4'd5: sh_din[31:0]  = d;
      4'd8: if (DEC_EN) sh_mode = d[0];
      default: ;
    endcase
  endtask

  task automatic rd_raw(input bit en_n, input bit rdn, input logic [3:0] a, input logic [31:0] e, input string n);
    enable_n = en_n; write_n = 1'b1; read_n = rdn; address = a; chk_valid = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
    tick();
    idle();
  endtask

  function automatic logic [31:0] shadow_reg(input logic [3:0] a);
    case (a)
      4'd0:    return {31'b0, sh_done};
      4'd1:    return sh_key[79:48];
      4'd2:    return sh_key[47:16];
      4'd3:    return {16'b0, sh_key[15:0]};
      4'd4:    return sh_din[63:32];
      4'd5:    return sh_din[31:0];
      4'd6:    return sh_dout[63:32];
      4'd7:    return sh_dout[31:0];
      4'd8:    return {31'b0, sh_mode};
      default: return 32'd0;
    endcase
  endfunction

  task automatic rd(input logic [3:0] a, input string n);
    rd_raw(1'b0, 1'b0, a, shadow_reg(a), n);
  endtask

  task automatic set_op(input logic [79:0] k, input logic [63:0] d, input bit m);
    wr(4'd1, k[79:48]);
    wr(4'd2, k[47:16]);
    wr(4'd3, {16'h0, k[15:0]});
    wr(4'd4, d[63:32]);
    wr(4'd5, d[31:0]);
    wr(4'd8, {31'b0, m});
  endtask

  // Start held for 'hold' cycles, then poll done every cycle (exact
  // latency), with operand writes and a stray start while busy.
  task automatic run_op(input int hold, input bit use_known, input logic [63:0] known, input string n);
    logic [63:0] e;
    int          lat;
    e   = use_known ? known : model(sh_key, sh_din, sh_mode);
    lat = sh_mode ? 64 : 33;
    $display("op   %s: key=%020h din=%016h mode=%0d expect=%016h", n, sh_key, sh_din, sh_mode, e);
    for (int h = 0; h < hold; h++) begin
      enable_n = 1'b0; write_n = 1'b0; read_n = 1'b1; address = 4'd0; idat = 32'd1;
      tick();
    end
    idle();
    sh_done = 1'b0;
    for (int k = hold - 1; k <= lat; k++) begin
      if (k == 5)       wr(4'd4, $urandom);
      else if (k == 6)  wr(4'd1, $urandom);
      else if (k == 8)  wr(4'd0, 32'd1);
      else              rd_raw(1'b0, 1'b0, 4'd0, {31'b0, k >= lat}, $sformatf("%s_done_c%0d", n, k));
    end
    sh_done = 1'b1;
    sh_dout = e;
    rd(4'd6, {n, "_dout0"});
    rd(4'd7, {n, "_dout1"});
    rd(4'd4, {n, "_din0_kept"});
    rd(4'd1, {n, "_key0_kept"});
  endtask

  task automatic clear_shadow();
    sh_key = '0; sh_din = '0; sh_dout = '0; sh_mode = 1'b0; sh_done = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    clear_shadow();

    // Reset state
    for (int a = 0; a < 9; a++) rd(4'(a), $sformatf("reset_reg%0d", a));

    // Bus behaviour
    wr(4'd1, 32'hdeadbeef);
    rd_raw(1'b0, 1'b1, 4'd1, 32'd0, "read_n_high");
    rd_raw(1'b1, 1'b0, 4'd1, 32'd0, "enable_n_high");
    rd(4'd1, "key0_rw");
    enable_n = 1'b1; write_n = 1'b0; address = 4'd1; idat = 32'h12345678;
    tick();
    idle();
    rd(4'd1, "write_no_select");
    wr(4'd12, 32'hffffffff);
    rd(4'd12, "addr12");
    wr(4'd3, 32'habcd1234);
    rd(4'd3, "key2_low16");
    wr(4'd8, 32'd1);
    rd(4'd8, "mode_rw");

    // Directed vectors
    set_op(80'h46657465_6c48636d_7573, 64'h4c746e67_7579656e, 1'b0);
    run_op(1, 1'b1, 64'h0e1d00d4_e46ba99c, "enc_vec1");
    set_op(80'h46657465_6c48636d_7573, 64'h0e1d00d4_e46ba99c, 1'b1);
    run_op(3, DEC_EN, 64'h4c746e67_7579656e, "dec_vec1");
    set_op(80'h00000000_00000000_0001, 64'h46657465_6c5f5553, 1'b0);
    run_op(1, 1'b1, 64'h9346f086_b0b1c9b4, "enc_vec2");
    set_op(80'h00000000_00000000_0001, 64'h9346f086_b0b1c9b4, 1'b1);
    run_op(2, DEC_EN, 64'h46657465_6c5f5553, "dec_vec2");

    // Randomised operations against the reference model
    for (int r = 0; r < 6; r++) begin
      set_op({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      run_op(1 + $urandom_range(0, 2), 1'b0, 64'd0, $sformatf("rand%0d", r));
    end

    // Reset in the middle of an encrypt aborts it
    set_op({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom}, 1'b0);
    wr(4'd0, 32'd1);
    repeat (10) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    clear_shadow();
    repeat (40) tick();
    rd(4'd0, "abort_done");
    rd(4'd6, "abort_dout0");
    rd(4'd7, "abort_dout1");
    rd(4'd1, "abort_key0");
    rd(4'd4, "abort_din0");

    // All-zero key and block after reset: standard vector
    run_op(1, 1'b1, 64'h5579c138_7b228445, "enc_zero");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
